// File: rtl/uart_tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop, at one of four baud rates.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (12-bit frame).
module uart_tx_unit #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int DIV_W    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] data_in,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   output logic       data_tx,
   output logic       active_flag,
   output logic       done_flag
);

`ifdef UART_TX_TWO_STOP_EN
   localparam int FRAME_W = 12;
`else
   localparam int FRAME_W = 11;
`endif
   localparam logic [3:0]       LAST_BIT  = 4'(FRAME_W - 1);
   localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(CLK_FREQ / 2400);
   localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_FREQ / 4800);
   localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_FREQ / 9600);
   localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_FREQ / 19200);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             r_state, w_state_next;
   logic [FRAME_W-1:0] r_frame, w_frame_next, w_frame_load;
   logic [3:0]         r_bit_cnt, w_bit_cnt_next;
   logic [DIV_W-1:0]   r_baud_cnt, w_baud_cnt_next;
   logic [DIV_W-1:0]   r_div_last, w_div_last_next;
   logic               r_tx, w_tx_next;
   logic               r_active, w_active_next;
   logic               r_done, w_done_next;
   logic               w_bit_end;

   function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] t);
      case (t)
         2'b01:   parity_bit = ~^d;
         2'b10:   parity_bit = ^d;
         default: parity_bit = 1'b1;
      endcase
   endfunction

   // Terminal count of the baud counter (D-1) for the selected rate.
   function automatic logic [DIV_W-1:0] div_last(input logic [1:0] b);
      case (b)
         2'b00:   div_last = DIV_2400  - DIV_W'(1);
         2'b01:   div_last = DIV_4800  - DIV_W'(1);
         2'b10:   div_last = DIV_9600  - DIV_W'(1);
         default: div_last = DIV_19200 - DIV_W'(1);
      endcase
   endfunction

   // Stop bit(s) fill the upper slots; start bit sits in bit 0 and goes out first.
   assign w_frame_load = {{(FRAME_W-10){1'b1}}, parity_bit(data_in, parity_type), data_in, 1'b0};
   assign w_bit_end    = (r_baud_cnt == r_div_last);

   // Next-state and next-output logic.
   always_comb begin
      w_state_next    = r_state;
      w_frame_next    = r_frame;
      w_bit_cnt_next  = r_bit_cnt;
      w_baud_cnt_next = r_baud_cnt;
      w_div_last_next = r_div_last;
      w_tx_next       = r_tx;
      w_active_next   = r_active;
      w_done_next     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tx_next     = 1'b1;
            w_active_next = 1'b0;
            if (send) begin
               w_state_next    = ST_SHIFT;
               w_frame_next    = w_frame_load;
               w_tx_next       = w_frame_load[0];
               w_bit_cnt_next  = 4'd0;
               w_baud_cnt_next = '0;
               w_div_last_next = div_last(baud_rate);
               w_active_next   = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            w_active_next = 1'b1;
            if (w_bit_end) begin
               w_baud_cnt_next = '0;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_next  = ST_IDLE;
                  w_done_next   = 1'b1;
                  w_active_next = 1'b0;
                  w_tx_next     = 1'b1;
               end else begin
                  w_frame_next   = {1'b1, r_frame[FRAME_W-1:1]};
                  w_tx_next      = r_frame[1];
                  w_bit_cnt_next = r_bit_cnt + 4'd1;
               end
            end else begin
               w_baud_cnt_next = r_baud_cnt + DIV_W'(1);
            end
         end
         default: begin
            w_state_next  = ST_IDLE;
            w_tx_next     = 1'b1;
            w_active_next = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_frame    <= '1;
         r_bit_cnt  <= 4'd0;
         r_baud_cnt <= '0;
         r_div_last <= '0;
         r_tx       <= 1'b1;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_frame    <= w_frame_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_baud_cnt <= w_baud_cnt_next;
         r_div_last <= w_div_last_next;
         r_tx       <= w_tx_next;
         r_active   <= w_active_next;
         r_done     <= w_done_next;
      end
   end

   assign data_tx     = r_tx;
   assign active_flag = r_active;
   assign done_flag   = r_done;

endmodule
